cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface: captures zero/negative/carry (plus overflow) from the Execute stage into an architectural NZCV register.
- Resolves LEGv8 B.cond branches against those flags.
- Sits directly after the 64-bit ALU.
- Delivers a registered taken/not-taken decision to the fetch/PC logic over a valid/ready handshake.

Parameters:
- COND_W, 4, width of branch condition code
- FLAG_RST, 4'b0000, reset value of NZCV register

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- alu_valid  in  1  ALU result/flags valid this cycle
- alu_setflags  in  1  instruction is flag-setting (ADDS/SUBS/ANDS)
- alu_zero  in  1  ALU zero flag
- alu_negative  in  1  ALU negative flag (result[63])
- alu_carry  in  1  ALU carry-out (SUB: 1 = no borrow)
- alu_overflow  in  1  ALU signed overflow
- br_valid  in  1  branch request present
- br_cond  in  COND_W  condition code
- br_ready  out  1  unit accepts branch this cycle
- out_valid  out  1  decision valid
- out_taken  out  1  1 = branch taken
- out_ready  in  1  downstream accepts decision
- nzcv  out  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset (rst_n low at a clock edge):
  - nzcv = FLAG_RST, out_valid = 0, out_taken = 0, FSM = IDLE.
  - Any decision in flight is discarded.
  - br_ready is 0 while rst_n is low.
- Flag write: alu_valid & alu_setflags at an edge loads nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow}. Otherwise nzcv holds.
  - alu_valid without setflags: no change.
  - setflags without alu_valid: ignored.
- Forwarding: effective flags for a branch = incoming ALU flags when alu_valid & alu_setflags in the same cycle, else nzcv. Same-cycle flag-set then branch always uses the new flags.
- Condition evaluation (effective N,Z,C,V):
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 HS C
  - 0011 LO !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 NV treated as 1
- FSM, states IDLE and HOLD:
  - IDLE: out_valid = 0.
  - In IDLE, br_valid & br_ready: register decision. Next state HOLD, out_valid = 1, out_taken = result. Latency 1 cycle.
  - HOLD & out_ready & br_valid: new decision replaces old (back-to-back, 1 per cycle), stay HOLD.
  - HOLD & out_ready & !br_valid: go to IDLE, out_valid = 0.
  - HOLD & !out_ready: out_valid and out_taken held stable, nzcv still updates.
- br_ready = rst_n & (state==IDLE | out_ready), combinational.
- Flags used are those effective in the acceptance cycle. A later flag write never alters a held decision.

Optional Feature:
- Macro COND_FLAG_STATS_EN.
- When defined, adds two output ports:
  - stat_taken, 32-bit: increments on each accepted branch resolved taken.
  - stat_not_taken, 32-bit: increments on each accepted branch resolved not taken.
- Counters reset to 0, wrap at 2^32-1 -> 0, count on acceptance, not on output handshake.
- When undefined, the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then SUBS 10-10 (alu_zero=1, alu_carry=1, N=0, V=0) -> nzcv=4'b0110. Branch EQ next cycle -> out_valid=1, out_taken=1 one cycle after acceptance. NE -> out_taken=0.
- SUBS 5-10 (N=1, C=0, V=0) -> nzcv=4'b1000. LT -> taken=1, HS -> taken=0, GE -> taken=0, LE -> taken=1.
- Same cycle: nzcv=0000, SUBS flags Z=1,C=1 presented with branch EQ -> taken=1 (forwarded), nzcv=0110 next cycle.
- ADD (setflags=0) with alu_zero=1 after nzcv=0000 -> nzcv stays 0000, EQ -> taken=0.
- Backpressure: accept NE (taken=1), hold out_ready=0 for 3 cycles while a new SUBS sets Z=1 -> out_taken stays 1, br_ready=0. Raise out_ready with br_valid EQ -> next cycle out_taken=1, back-to-back, no gap.
- Reset mid-operation: out_valid=1 in HOLD, assert rst_n=0 for one edge -> out_valid=0, nzcv=0000, br_ready=0 during reset. With COND_FLAG_STATS_EN, counters=0.

Source files
------------

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: ALU flag, branch request and decision signals for cond_flag_unit.
// Rev 1.0 - initial release.
`default_nettype none

interface cond_flag_unit_if #(
    parameter int COND_W = 4
);
    logic              alu_valid;
    logic              alu_setflags;
    logic              alu_zero;
    logic              alu_negative;
    logic              alu_carry;
    logic              alu_overflow;
    logic              br_valid;
    logic [COND_W-1:0] br_cond;
    logic              br_ready;
    logic              out_valid;
    logic              out_taken;
    logic              out_ready;
    logic [3:0]        nzcv;

    modport master (
        output alu_valid, alu_setflags, alu_zero, alu_negative, alu_carry, alu_overflow,
        output br_valid, br_cond, out_ready,
        input  br_ready, out_valid, out_taken, nzcv
    );

    modport slave (
        input  alu_valid, alu_setflags, alu_zero, alu_negative, alu_carry, alu_overflow,
        input  br_valid, br_cond, out_ready,
        output br_ready, out_valid, out_taken, nzcv
    );
endinterface

`default_nettype wire

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register and LEGv8 B.cond resolver with a registered decision output.
// Optional COND_FLAG_STATS_EN adds taken/not-taken counters. Rev 1.0 - initial release.
`default_nettype none

module cond_flag_unit #(
    parameter int         COND_W   = 4,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cond_flag_unit_if.slave    bus
`ifdef COND_FLAG_STATS_EN
    ,
    output logic [31:0]        stat_taken,
    output logic [31:0]        stat_not_taken
`endif
);

    localparam logic [COND_W-1:0] c_eq = COND_W'(4'h0);
    localparam logic [COND_W-1:0] c_ne = COND_W'(4'h1);
    localparam logic [COND_W-1:0] c_hs = COND_W'(4'h2);
    localparam logic [COND_W-1:0] c_lo = COND_W'(4'h3);
    localparam logic [COND_W-1:0] c_mi = COND_W'(4'h4);
    localparam logic [COND_W-1:0] c_pl = COND_W'(4'h5);
    localparam logic [COND_W-1:0] c_vs = COND_W'(4'h6);
    localparam logic [COND_W-1:0] c_vc = COND_W'(4'h7);
    localparam logic [COND_W-1:0] c_hi = COND_W'(4'h8);
    localparam logic [COND_W-1:0] c_ls = COND_W'(4'h9);
    localparam logic [COND_W-1:0] c_ge = COND_W'(4'hA);
    localparam logic [COND_W-1:0] c_lt = COND_W'(4'hB);
    localparam logic [COND_W-1:0] c_gt = COND_W'(4'hC);
    localparam logic [COND_W-1:0] c_le = COND_W'(4'hD);
    localparam logic [COND_W-1:0] c_al = COND_W'(4'hE);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_nzcv;
    logic              r_taken;
    logic              w_flag_wr;
    logic [3:0]        w_flags;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic              w_taken;
    logic              w_br_ready;
    logic              w_accept;

    // A flag-setting op in the same cycle as a branch is forwarded so the branch sees it.
    assign w_flag_wr = bus.alu_valid & bus.alu_setflags;
    assign w_flags   = w_flag_wr ? {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow}
                                 : r_nzcv;
    assign {w_n, w_z, w_c, w_v} = w_flags;

    always_comb begin
        w_taken = 1'b1;
        case (bus.br_cond)
            c_eq:    w_taken = w_z;
            c_ne:    w_taken = ~w_z;
            c_hs:    w_taken = w_c;
            c_lo:    w_taken = ~w_c;
            c_mi:    w_taken = w_n;
            c_pl:    w_taken = ~w_n;
            c_vs:    w_taken = w_v;
            c_vc:    w_taken = ~w_v;
            c_hi:    w_taken = w_c & ~w_z;
            c_ls:    w_taken = ~w_c | w_z;
            c_ge:    w_taken = (w_n == w_v);
            c_lt:    w_taken = (w_n != w_v);
            c_gt:    w_taken = ~w_z & (w_n == w_v);
            c_le:    w_taken = w_z | (w_n != w_v);
            c_al:    w_taken = 1'b1;
            default: w_taken = 1'b1;
        endcase
    end

    assign w_br_ready = rst_n & ((r_state == S_IDLE) | bus.out_ready);
    assign w_accept   = bus.br_valid & w_br_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready && !bus.br_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_nzcv  <= FLAG_RST;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flag_wr) begin
                r_nzcv <= w_flags;
            end
            if (w_accept) begin
                r_taken <= w_taken;
            end
        end
    end

    assign bus.br_ready  = w_br_ready;
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_taken = r_taken;
    assign bus.nzcv      = r_nzcv;

`ifdef COND_FLAG_STATS_EN
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_not_taken;

    // Counted at acceptance so stalls on the output side do not skew the totals.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_taken     <= 32'd0;
            r_stat_not_taken <= 32'd0;
        end else if (w_accept) begin
            if (w_taken) begin
                r_stat_taken <= r_stat_taken + 32'd1;
            end else begin
                r_stat_not_taken <= r_stat_not_taken + 32'd1;
            end
        end
    end

    assign stat_taken     = r_stat_taken;
    assign stat_not_taken = r_stat_not_taken;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: table vectors, hand sequences and randomized model check of cond_flag_unit.
// Rev 1.0 - initial release.
`default_nettype none

module tb_cond_flag_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cond_flag_unit_if #(.COND_W(4)) bus ();

`ifdef COND_FLAG_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
`endif

    cond_flag_unit #(
        .COND_W   (4),
        .FLAG_RST (4'b0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef COND_FLAG_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken)
`endif
    );

    typedef struct {
        logic       av;
        logic       sf;
        logic [3:0] fl;
        logic       bv;
        logic [3:0] cond;
        logic       ordy;
        logic       ev;
        logic       et;
        logic [3:0] en;
    } vec_t;

    vec_t tbl[21];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       m_valid;
    logic       m_taken;
    logic [3:0] m_nzcv;
    int unsigned m_st;
    int unsigned m_snt;
    logic       r_av, r_sf, r_bv, r_ordy, exp_rdy;
    logic [3:0] r_fl, r_cond, eff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic sf, input logic [3:0] fl,
                         input logic bv, input logic [3:0] cond, input logic ordy);
        bus.alu_valid    = av;
        bus.alu_setflags = sf;
        bus.alu_negative = fl[3];
        bus.alu_zero     = fl[2];
        bus.alu_carry    = fl[1];
        bus.alu_overflow = fl[0];
        bus.br_valid     = bv;
        bus.br_cond      = cond;
        bus.out_ready    = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural form: cond[3:1] picks the base predicate, cond[0] inverts it (except 111x).
    function automatic logic cond_true(input logic [3:0] f, input logic [3:0] cond);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0] && cond[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            av    sf    flags    bv    cond     ordy  ev    et    nzcv
        tbl[0]  = '{1'b1, 1'b1, 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0110};
        tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0110};
        tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0110};
        tbl[3]  = '{1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000};
        tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 4'b1000};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b1000};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 4'b1000};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b1101, 1'b1, 1'b1, 1'b1, 4'b1000};
        tbl[8]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[9]  = '{1'b1, 1'b1, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0110};
        tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[11] = '{1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[13] = '{1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[14] = '{1'b1, 1'b1, 4'b0010, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0010};
        tbl[15] = '{1'b1, 1'b1, 4'b0001, 1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 4'b0001};
        tbl[16] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b0001};
        tbl[17] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001};
        tbl[18] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0001};
        tbl[19] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 4'b0001};
        tbl[20] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001};

        // Power-on reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
        #1;
        chk("rst_br_ready_low", bus.br_ready, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_taken", bus.out_taken, 1'b0);
        chk("rst_nzcv", bus.nzcv, 4'b0000);
        rst_n = 1'b1;
        #1;
        chk("idle_br_ready", bus.br_ready, 1'b1);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].av, tbl[i].sf, tbl[i].fl, tbl[i].bv, tbl[i].cond, tbl[i].ordy);
            tick();
            chk($sformatf("vec%0d_out_valid", i), bus.out_valid, tbl[i].ev);
            chk($sformatf("vec%0d_nzcv", i), bus.nzcv, tbl[i].en);
            if (tbl[i].ev) chk($sformatf("vec%0d_out_taken", i), bus.out_taken, tbl[i].et);
        end

        // Backpressure: held decision survives flag writes, then back-to-back resumes
        drive(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1);
        tick();
        chk("bp_accept_valid", bus.out_valid, 1'b1);
        chk("bp_accept_taken", bus.out_taken, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0);
            #1;
            chk($sformatf("bp%0d_br_ready", k), bus.br_ready, 1'b0);
            tick();
            chk($sformatf("bp%0d_out_valid", k), bus.out_valid, 1'b1);
            chk($sformatf("bp%0d_out_taken", k), bus.out_taken, 1'b1);
            chk($sformatf("bp%0d_nzcv", k), bus.nzcv, 4'b0100);
        end
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1);
        #1;
        chk("bp_release_br_ready", bus.br_ready, 1'b1);
        tick();
        chk("bp_eq_valid", bus.out_valid, 1'b1);
        chk("bp_eq_taken", bus.out_taken, 1'b1);
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1);
        tick();
        chk("b2b_ne_valid", bus.out_valid, 1'b1);
        chk("b2b_ne_taken", bus.out_taken, 1'b0);

        // Reset while holding a decision; also a flag write presented during reset
        drive(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1110, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_br_ready", bus.br_ready, 1'b0);
        tick();
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_out_taken", bus.out_taken, 1'b0);
        chk("midrst_nzcv", bus.nzcv, 4'b0000);
        chk("midrst_br_ready_after_edge", bus.br_ready, 1'b0);
`ifdef COND_FLAG_STATS_EN
        chk("midrst_stat_taken", stat_taken, 32'd0);
        chk("midrst_stat_not_taken", stat_not_taken, 32'd0);
`endif
        rst_n = 1'b1;

        // Randomized run against the reference model
        m_valid = 1'b0;
        m_taken = 1'b0;
        m_nzcv  = 4'b0000;
        m_st    = 0;
        m_snt   = 0;
        for (int i = 0; i < 400; i++) begin
            r_av   = 1'($urandom_range(0, 1));
            r_sf   = 1'($urandom_range(0, 1));
            r_fl   = 4'($urandom);
            r_bv   = ($urandom_range(0, 3) != 0);
            r_cond = 4'($urandom);
            r_ordy = ($urandom_range(0, 3) != 0);
            drive(r_av, r_sf, r_fl, r_bv, r_cond, r_ordy);
            #1;
            exp_rdy = !m_valid || r_ordy;
            chk("rnd_br_ready", bus.br_ready, exp_rdy);
            eff = (r_av && r_sf) ? r_fl : m_nzcv;
            if (r_bv && exp_rdy) begin
                m_valid = 1'b1;
                m_taken = cond_true(eff, r_cond);
                if (m_taken) m_st++;
                else m_snt++;
            end else if (m_valid && r_ordy) begin
                m_valid = 1'b0;
            end
            if (r_av && r_sf) m_nzcv = r_fl;
            tick();
            chk("rnd_out_valid", bus.out_valid, m_valid);
            chk("rnd_nzcv", bus.nzcv, m_nzcv);
            if (m_valid) chk("rnd_out_taken", bus.out_taken, m_taken);
        end
`ifdef COND_FLAG_STATS_EN
        chk("rnd_stat_taken", stat_taken, m_st);
        chk("rnd_stat_not_taken", stat_not_taken, m_snt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
